// File: rtl/sign_extend.sv
// sign_extend: registered immediate widener for the decode stage.
// Widens a 16-bit immediate to 32 bits (sign, zero, upper-half or byte-sign)
// and presents the result one clock after an in_valid cycle.
module sign_extend (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [1:0]  mode,
  input  logic        in_valid,
  output logic [31:0] y,
  output logic        out_valid,
  output logic        neg
);

  localparam logic [1:0] MODE_SIGN  = 2'b00;
  localparam logic [1:0] MODE_ZERO  = 2'b01;
  localparam logic [1:0] MODE_UPPER = 2'b10;
  localparam logic [1:0] MODE_BYTE  = 2'b11;

  logic [31:0] ext_val;
  logic [31:0] y_d,         y_q;
  logic        neg_d,       neg_q;
  logic        out_valid_d, out_valid_q;

  // Extension function ahead of the output register; a[15:8] unused in byte mode.
  always_comb begin
    ext_val = 32'h0000_0000;
    unique case (mode)
      MODE_SIGN:  ext_val = {{16{a[15]}}, a};
      MODE_ZERO:  ext_val = {16'h0000, a};
      MODE_UPPER: ext_val = {a, 16'h0000};
      MODE_BYTE:  ext_val = {{24{a[7]}}, a[7:0]};
      default:    ext_val = 32'h0000_0000;
    endcase
  end

  // Next-state: capture on in_valid, otherwise hold the result and drop valid.
  // neg is derived from the same value as y so it always tracks y[31].
  always_comb begin
    y_d         = y_q;
    neg_d       = neg_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      y_d         = ext_val;
      neg_d       = ext_val[31];
      out_valid_d = 1'b1;
    end
  end

  // Output registers; reset wins over a same-cycle valid input.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q         <= 32'h0000_0000;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      y_q         <= y_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign y         = y_q;
  assign neg       = neg_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_sign_extend.sv
// Bench for sign_extend: directed cases plus random traffic, checked by a
// scoreboard against an arithmetic reference model.
module tb_sign_extend;

  logic        clk;
  logic        reset;
  logic [15:0] a;
  logic [1:0]  mode;
  logic        in_valid;
  logic [31:0] y;
  logic        out_valid;
  logic        neg;

  sign_extend dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .mode      (mode),
    .in_valid  (in_valid),
    .y         (y),
    .out_valid (out_valid),
    .neg       (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] y;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_y = 32'h0;

  // Reference extension written as plain arithmetic on signed/unsigned values.
  function automatic logic [31:0] ref_ext(input logic [15:0] av, input logic [1:0] m);
    logic [7:0] lo;
    lo = av[7:0];
    case (m)
      2'd0:    return 32'($signed(av));
      2'd1:    return 32'(av);
      2'd2:    return 32'(av) * 32'd65536;
      default: return 32'($signed(lo));
    endcase
  endfunction

  // One cycle: drive inputs, wait for the edge, record what that edge should produce.
  task automatic cyc(input logic r, input logic v, input logic [15:0] av,
                     input logic [1:0] m, input string nm);
    exp_t e;
    reset    = r;
    in_valid = v;
    a        = av;
    mode     = m;
    @(posedge clk);
    if (r)      model_y = 32'h0;
    else if (v) model_y = ref_ext(av, m);
    e.v    = !r && v;
    e.y    = model_y;
    e.name = nm;
    sb.push_back(e);
    #1;
  endtask

  // Monitor: one expectation per edge, compared at the following falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic exp_neg;
      e = sb.pop_front();
      exp_neg = e.y[31];
      total++;
      if (out_valid !== e.v) begin
        bad++;
        $display("FAIL %s out_valid: got %b want %b", e.name, out_valid, e.v);
      end
      total++;
      if (y !== e.y) begin
        bad++;
        $display("FAIL %s y: got %h want %h", e.name, y, e.y);
      end
      total++;
      if (neg !== exp_neg) begin
        bad++;
        $display("FAIL %s neg: got %b want %b", e.name, neg, exp_neg);
      end
    end
  end

  initial begin
    int waited;
    reset = 1'b1; in_valid = 1'b0; a = 16'h0; mode = 2'd0;

    cyc(1'b1, 1'b1, 16'hFFFF, 2'd0, "reset0");
    cyc(1'b1, 1'b1, 16'hFFFF, 2'd0, "reset1");

    cyc(1'b0, 1'b1, 16'h0000, 2'd0, "sx_0000");
    cyc(1'b0, 1'b1, 16'h0001, 2'd0, "sx_0001");
    cyc(1'b0, 1'b1, 16'h7FFF, 2'd0, "sx_7fff");
    cyc(1'b0, 1'b1, 16'h8000, 2'd0, "sx_8000");
    cyc(1'b0, 1'b1, 16'hFFFF, 2'd0, "sx_ffff");

    cyc(1'b0, 1'b1, 16'h8001, 2'd1, "zero_8001");
    cyc(1'b0, 1'b1, 16'h8001, 2'd2, "upper_8001");

    cyc(1'b0, 1'b1, 16'h12F0, 2'd3, "byte_12f0");
    cyc(1'b0, 1'b1, 16'hAB7F, 2'd3, "byte_ab7f");

    cyc(1'b0, 1'b1, 16'h1234, 2'd0, "hold_load");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 16'hFFFF, 2'(i), "hold");

    cyc(1'b1, 1'b1, 16'h8000, 2'd0, "rst_collide");
    cyc(1'b0, 1'b1, 16'h8000, 2'd0, "after_rst");

    for (int i = 0; i < 400; i++) begin
      logic        r, v;
      logic [15:0] av;
      logic [1:0]  m;
      r  = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 9) < 7);
      av = 16'($urandom);
      m  = 2'($urandom_range(0, 3));
      cyc(r, v, av, m, "random");
    end

    cyc(1'b0, 1'b0, 16'h0, 2'd0, "drain");

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
